sync_timing_decoder: RTL
========================

# sync_timing_decoder

Receive-side counterpart of the hsync/vsync video timer. Samples active-low hsync and vsync from a timer or an external source. Measures the line period in clocks and the frame period in lines, then locks onto a stable timing. Once locked, regenerates xposition, yposition and an active-video flag for downstream pixel consumers such as a capture buffer or overlay logic.

## Interface
- resolution, 10: width of all counters, positions and timing inputs/outputs
- clock  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
- hsync  in  1  active-low horizontal sync, synchronous to clock
- vsync  in  1  active-low vertical sync, synchronous to clock
- HBackPorch, VBackPorch  in  resolution  clocks / lines from sync deassertion to first active pixel / line
- HActive, VActive  in  resolution  active pixels per line / active lines per frame
- xposition, yposition  out  resolution  recovered pixel position
- active  out  1  high when xposition < HActive and yposition < VActive and locked
- locked  out  1  timing stable
- LinePeriod  out  resolution  last measured clocks between hsync rising edges
- FramePeriod  out  resolution  last measured lines between vsync rising edges
- SyncError  out  1  one-cycle pulse when lock is lost

## Operation
- Input stage: hsync/vsync registered once (hs_q, vs_q), then again (hs_qq, vs_qq). Rise = q & ~qq.
- hcount: +1 per clock. Loads 0 on hsync rise. Saturates at all-ones.
- vcount: +1 on each hsync rise. A vsync rise sets vs_pend. The next hsync rise loads vcount = 0 and clears vs_pend. vcount saturates at all-ones.
- xposition = hcount − HBackPorch, yposition = vcount − VBackPorch, both mod 2^resolution. A wrapped (huge) value means porch region; active is then low.
- On hsync rise: LinePeriod <= hcount + 1. On the vcount-zeroing hsync rise: FramePeriod <= vcount + 1.
- FSM states SEARCH, MEASURE, VERIFY, LOCKED:
  - SEARCH → MEASURE at first vcount-zeroing event. Capture ref_line at the first subsequent hsync rise.
  - MEASURE → VERIFY at next vcount-zeroing event. Capture ref_frame.
  - VERIFY: every line period must equal ref_line and the frame period must equal ref_frame. On a full matching frame → LOCKED. On any mismatch → SEARCH; SyncError is not pulsed.
  - LOCKED: any line or frame period mismatch → SEARCH, SyncError pulses for 1 cycle.
- locked = (state == LOCKED).
- A hsync rise and a vsync rise on the same cycle: the vsync rise is recorded in vs_pend. That same hsync rise does not consume it; zeroing occurs on the following hsync rise.
- Reset values: hcount = vcount = 0, vs_pend = 0, LinePeriod = FramePeriod = 0, state SEARCH, locked = 0, active = 0, SyncError = 0. The input registers reset to 1 (idle sync).
- Reset asserted mid-frame: all state returns to reset values on that edge. Relock requires a full SEARCH → LOCKED sequence (≥ 2 frames plus partial).

## Timing
- hsync rise at input, sampled at edge n: hs_q=1 after n, rise detected during cycle after n. hcount = 0 after edge n+1 (2-clock latency).
- xposition/yposition/active are combinational from counters; no extra latency.
- LinePeriod/FramePeriod update on the same edge as the counter reload.
- locked rises on the edge that completes the VERIFY frame; it falls on the edge the mismatch is detected.

## Configuration
- SYNC_DECODER_TIMEOUT_EN defined: saturation of hcount (no hsync rise for 2^resolution − 1 clocks) or of vcount is treated as a mismatch. In LOCKED, it forces SEARCH and pulses SyncError.
- Not defined: counters saturate and hold. Lock and outputs freeze until the next sync edge, and only an edge-time mismatch drops lock.

## Test plan
- Source: line 16 clocks (HActive 8, HBackPorch 3, sync 3), frame 12 lines (VActive 6, VBackPorch 2). Run 4 frames → locked high within frame 3, LinePeriod = 16, FramePeriod = 12, xposition 0..7 with active high for 8 clocks per active line.
- While locked, stretch one line to 17 clocks → SyncError one pulse, locked low, state SEARCH. Relock after 2 further clean frames.
- Assert reset for 1 cycle mid-frame while locked → locked = 0, positions = 0 − porch, LinePeriod = 0 next cycle. Relock as in test 1.
- Same-cycle hsync and vsync rises → vcount zeroes on the following hsync rise, not the current one. yposition sequence is unchanged vs. test 1.
- Stop hsync (held high) 1100 clocks while locked → with SYNC_DECODER_TIMEOUT_EN: SyncError at saturation (hcount = 1023), locked low. Without: locked stays high, hcount holds 1023.

Source files
------------

// File: rtl/sync_timing_decoder_if.sv
// Sync and recovered-timing bundle between a video timing source and sync_timing_decoder.
// The source side uses modport master; the decoder side uses modport slave.
interface sync_timing_decoder_if #(
  parameter int resolution = 10
);
  logic                  hsync;
  logic                  vsync;
  logic [resolution-1:0] HBackPorch;
  logic [resolution-1:0] VBackPorch;
  logic [resolution-1:0] HActive;
  logic [resolution-1:0] VActive;
  logic [resolution-1:0] xposition;
  logic [resolution-1:0] yposition;
  logic                  active;
  logic                  locked;
  logic [resolution-1:0] LinePeriod;
  logic [resolution-1:0] FramePeriod;
  logic                  SyncError;

  modport master (
    output hsync, vsync, HBackPorch, VBackPorch, HActive, VActive,
    input  xposition, yposition, active, locked, LinePeriod, FramePeriod, SyncError
  );

  modport slave (
    input  hsync, vsync, HBackPorch, VBackPorch, HActive, VActive,
    output xposition, yposition, active, locked, LinePeriod, FramePeriod, SyncError
  );
endinterface

// File: rtl/sync_timing_decoder.sv
// Measures line/frame periods from active-low hsync/vsync, locks onto stable timing and
// regenerates pixel position and active video. Define SYNC_DECODER_TIMEOUT_EN to drop lock on counter saturation.
module sync_timing_decoder #(
  parameter int resolution = 10
) (
  input logic                  clock,
  input logic                  reset,
  sync_timing_decoder_if.slave bus
);
  typedef enum logic [1:0] {SEARCH, MEASURE, VERIFY, LOCKED} state_t;

  localparam logic [resolution-1:0] CntMax = '1;
  localparam logic [resolution-1:0] CntOne = {{(resolution-1){1'b0}}, 1'b1};

  logic                  hs_q, hs_qq, vs_q, vs_qq;
  logic                  hs_rise, vs_rise, zero_evt;
  logic [resolution-1:0] hcount_q, hcount_d;
  logic [resolution-1:0] vcount_q, vcount_d;
  logic                  vs_pend_q, vs_pend_d;
  logic [resolution-1:0] line_period_q, line_period_d;
  logic [resolution-1:0] frame_period_q, frame_period_d;
  logic [resolution-1:0] ref_line_q, ref_line_d;
  logic [resolution-1:0] ref_frame_q, ref_frame_d;
  logic                  ref_line_valid_q, ref_line_valid_d;
  logic                  sync_error_q, sync_error_d;
  state_t                state_q, state_d;
  logic [resolution-1:0] line_meas, frame_meas;
  logic                  line_bad, frame_bad, timeout, mismatch;
  logic [resolution-1:0] xpos, ypos;

  assign hs_rise    = hs_q & ~hs_qq;
  assign vs_rise    = vs_q & ~vs_qq;
  assign zero_evt   = hs_rise & vs_pend_q;
  assign line_meas  = hcount_q + CntOne;
  assign frame_meas = vcount_q + CntOne;

  // A vsync rise only arms vs_pend; the frame restarts on the hsync rise that follows it.
  always_comb begin
    hcount_d       = hcount_q;
    vcount_d       = vcount_q;
    vs_pend_d      = vs_pend_q;
    line_period_d  = line_period_q;
    frame_period_d = frame_period_q;
    if (hs_rise) begin
      hcount_d      = '0;
      line_period_d = line_meas;
    end else if (hcount_q != CntMax) begin
      hcount_d = line_meas;
    end
    if (zero_evt) begin
      vcount_d       = '0;
      frame_period_d = frame_meas;
    end else if (hs_rise && (vcount_q != CntMax)) begin
      vcount_d = frame_meas;
    end
    if (vs_rise) begin
      vs_pend_d = 1'b1;
    end else if (zero_evt) begin
      vs_pend_d = 1'b0;
    end
  end

`ifdef SYNC_DECODER_TIMEOUT_EN
  assign timeout = (hcount_q == CntMax) || (vcount_q == CntMax);
`else
  assign timeout = 1'b0;
`endif

  assign line_bad  = hs_rise && (line_meas != ref_line_q);
  assign frame_bad = zero_evt && (frame_meas != ref_frame_q);
  assign mismatch  = line_bad || frame_bad || timeout;

  always_comb begin
    state_d          = state_q;
    ref_line_d       = ref_line_q;
    ref_frame_d      = ref_frame_q;
    ref_line_valid_d = ref_line_valid_q;
    sync_error_d     = 1'b0;
    unique case (state_q)
      SEARCH: begin
        if (zero_evt) begin
          state_d          = MEASURE;
          ref_line_valid_d = 1'b0;
        end
      end
      MEASURE: begin
        if (hs_rise && !ref_line_valid_q) begin
          ref_line_d       = line_meas;
          ref_line_valid_d = 1'b1;
        end
        if (zero_evt) begin
          ref_frame_d = frame_meas;
          state_d     = VERIFY;
        end
      end
      VERIFY: begin
        if (mismatch) begin
          state_d = SEARCH;
        end else if (zero_evt) begin
          state_d = LOCKED;
        end
      end
      LOCKED: begin
        if (mismatch) begin
          state_d      = SEARCH;
          sync_error_d = 1'b1;
        end
      end
      default: state_d = SEARCH;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      hs_q             <= 1'b1;
      hs_qq            <= 1'b1;
      vs_q             <= 1'b1;
      vs_qq            <= 1'b1;
      hcount_q         <= '0;
      vcount_q         <= '0;
      vs_pend_q        <= 1'b0;
      line_period_q    <= '0;
      frame_period_q   <= '0;
      ref_line_q       <= '0;
      ref_frame_q      <= '0;
      ref_line_valid_q <= 1'b0;
      sync_error_q     <= 1'b0;
      state_q          <= SEARCH;
    end else begin
      hs_q             <= bus.hsync;
      hs_qq            <= hs_q;
      vs_q             <= bus.vsync;
      vs_qq            <= vs_q;
      hcount_q         <= hcount_d;
      vcount_q         <= vcount_d;
      vs_pend_q        <= vs_pend_d;
      line_period_q    <= line_period_d;
      frame_period_q   <= frame_period_d;
      ref_line_q       <= ref_line_d;
      ref_frame_q      <= ref_frame_d;
      ref_line_valid_q <= ref_line_valid_d;
      sync_error_q     <= sync_error_d;
      state_q          <= state_d;
    end
  end

  // Positions wrap to huge values inside the porches, which keeps active low there.
  assign xpos            = hcount_q - bus.HBackPorch;
  assign ypos            = vcount_q - bus.VBackPorch;
  assign bus.xposition   = xpos;
  assign bus.yposition   = ypos;
  assign bus.locked      = (state_q == LOCKED);
  assign bus.active      = (state_q == LOCKED) && (xpos < bus.HActive) && (ypos < bus.VActive);
  assign bus.LinePeriod  = line_period_q;
  assign bus.FramePeriod = frame_period_q;
  assign bus.SyncError   = sync_error_q;
endmodule
